gpio_irq_controller: RTL and testbench

- Parametrised successor to the board GPIO block: N LED outputs and M key inputs behind the same APB slave style.
- Adds board-polarity masks as parameters, per-key 2-flop synchroniser plus debounce, and rise/fall edge capture into a sticky W1C status register.
- Drives a single level interrupt line to the platform interrupt controller.

---
 rtl/gpio_pkg.sv | 21 ++
 rtl/gpio_debounce.sv | 72 +++++++
 rtl/gpio_irq_controller.sv | 124 ++++++++++++
 tb/tb_gpio_irq_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pkg
// Description : Shared constants for the GPIO/IRQ controller: register index
//               encoding (PADDR[4:2]) and the address-index width.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

    // Word-index width taken from PADDR[4:2]
    localparam int GPIO_ADDR_IDX_W = 3;

    // Register word indices (byte offset = index * 4)
    localparam logic [GPIO_ADDR_IDX_W-1:0] GPIO_REG_LED     = 3'd0; // 0x00
    localparam logic [GPIO_ADDR_IDX_W-1:0] GPIO_REG_KEYS    = 3'd1; // 0x04
    localparam logic [GPIO_ADDR_IDX_W-1:0] GPIO_REG_RISE_EN = 3'd2; // 0x08
    localparam logic [GPIO_ADDR_IDX_W-1:0] GPIO_REG_FALL_EN = 3'd3; // 0x0C
    localparam logic [GPIO_ADDR_IDX_W-1:0] GPIO_REG_STATUS  = 3'd4; // 0x10

endpackage : gpio_pkg
`default_nettype wire

// File: rtl/gpio_debounce.sv
`default_nettype none
// ============================================================================
// Module      : gpio_debounce
// Description : Single-key 2-flop synchroniser followed by a stability
//               counter. A change is accepted only after DEBOUNCE_CYCLES
//               consecutive synchronised cycles differing from the current
//               stable value; the accept cycle produces a one-cycle
//               combinational rise or fall pulse aligned with the update.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,        // synchronous, active-low
    input  logic raw_in,       // already polarity-normalised
    output logic stable_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1_q,  w_sync1_d;
    logic             r_sync2_q,  w_sync2_d;
    logic             r_stable_q, w_stable_d;
    logic [CNT_W-1:0] r_cnt_q,    w_cnt_d;
    logic             w_accept;

    // Next-state: shift the synchroniser and run the stability counter
    always_comb begin
        w_sync1_d  = raw_in;
        w_sync2_d  = r_sync1_q;
        w_stable_d = r_stable_q;
        w_cnt_d    = r_cnt_q;
        w_accept   = 1'b0;
        if (r_sync2_q == r_stable_q) begin
            // Input agrees with the accepted level: any partial count is a glitch
            w_cnt_d = '0;
        end else if (r_cnt_q == CNT_LAST) begin
            w_accept   = 1'b1;
            w_stable_d = r_sync2_q;
            w_cnt_d    = '0;
        end else begin
            w_cnt_d = r_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset drops any in-progress count
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1_q  <= 1'b0;
            r_sync2_q  <= 1'b0;
            r_stable_q <= 1'b0;
            r_cnt_q    <= '0;
        end else begin
            r_sync1_q  <= w_sync1_d;
            r_sync2_q  <= w_sync2_d;
            r_stable_q <= w_stable_d;
            r_cnt_q    <= w_cnt_d;
        end
    end

    assign stable_out = r_stable_q;
    // Pulses are valid in the cycle before the edge that updates stable_out,
    // so a status flop sampling them sets on the same edge as the key state.
    assign rise_pulse = w_accept &  r_sync2_q;
    assign fall_pulse = w_accept & ~r_sync2_q;

endmodule : gpio_debounce
`default_nettype wire

// File: rtl/gpio_irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : gpio_irq_controller
// Description : APB-style GPIO block with NUM_LEDS outputs and NUM_KEYS
//               debounced inputs, per-key rise/fall edge capture into a
//               sticky write-1-to-clear status register and a level IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_irq_controller
    import gpio_pkg::*;
#(
    parameter int                  NUM_LEDS        = 3,
    parameter int                  NUM_KEYS        = 2,
    parameter int                  DEBOUNCE_CYCLES = 16,
    parameter logic [NUM_LEDS-1:0] LED_INVERT      = '0,
    parameter logic [NUM_KEYS-1:0] KEY_INVERT      = '0
) (
    input  logic                clk,
    input  logic                reset,        // synchronous, active-low
    output logic [NUM_LEDS-1:0] leds,
    input  logic [NUM_KEYS-1:0] keys,
    output logic                irq,
    input  logic [4:0]          apb_PADDR,
    input  logic                apb_PSEL,
    input  logic                apb_PENABLE,
    output logic                apb_PREADY,
    input  logic                apb_PWRITE,
    input  logic [31:0]         apb_PWDATA,
    output logic [31:0]         apb_PRDATA
);

    logic [GPIO_ADDR_IDX_W-1:0] w_idx;
    logic                       w_wr;
    logic [NUM_KEYS-1:0]        w_key_n;
    logic [NUM_KEYS-1:0]        w_stable;
    logic [NUM_KEYS-1:0]        w_rise;
    logic [NUM_KEYS-1:0]        w_fall;
    logic [NUM_KEYS-1:0]        w_set;
    logic [NUM_KEYS-1:0]        w_clr;
    logic                       w_unused_ok;

    logic [NUM_LEDS-1:0] r_led_q,     w_led_d;
    logic [NUM_KEYS-1:0] r_rise_en_q, w_rise_en_d;
    logic [NUM_KEYS-1:0] r_fall_en_q, w_fall_en_d;
    logic [NUM_KEYS-1:0] r_status_q,  w_status_d;

    assign w_idx       = apb_PADDR[4:2];
    assign w_wr        = apb_PSEL & apb_PENABLE & apb_PWRITE;
    assign apb_PREADY  = 1'b1;
    // Byte-lane bits and unused write-data bits have no function here
    assign w_unused_ok = ^{apb_PADDR[1:0], apb_PWDATA};

    // Board polarity normalisation ahead of the synchronisers
    assign w_key_n = keys ^ KEY_INVERT;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            gpio_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk        (clk),
                .reset      (reset),
                .raw_in     (w_key_n[gi]),
                .stable_out (w_stable[gi]),
                .rise_pulse (w_rise[gi]),
                .fall_pulse (w_fall[gi])
            );
        end
    endgenerate

    // Register write decode and sticky status update (set beats clear)
    always_comb begin
        w_led_d     = r_led_q;
        w_rise_en_d = r_rise_en_q;
        w_fall_en_d = r_fall_en_q;
        w_clr       = '0;
        if (w_wr) begin
            case (w_idx)
                GPIO_REG_LED:     w_led_d     = apb_PWDATA[NUM_LEDS-1:0];
                GPIO_REG_RISE_EN: w_rise_en_d = apb_PWDATA[NUM_KEYS-1:0];
                GPIO_REG_FALL_EN: w_fall_en_d = apb_PWDATA[NUM_KEYS-1:0];
                GPIO_REG_STATUS:  w_clr       = apb_PWDATA[NUM_KEYS-1:0];
                default:          ;
            endcase
        end
        w_set      = (w_rise & r_rise_en_q) | (w_fall & r_fall_en_q);
        w_status_d = (r_status_q & ~w_clr) | w_set;
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_led_q     <= '0;
            r_rise_en_q <= '0;
            r_fall_en_q <= '0;
            r_status_q  <= '0;
        end else begin
            r_led_q     <= w_led_d;
            r_rise_en_q <= w_rise_en_d;
            r_fall_en_q <= w_fall_en_d;
            r_status_q  <= w_status_d;
        end
    end

    // Combinational read mux, zero-extended; idle bus reads as zero
    always_comb begin
        apb_PRDATA = '0;
        if (apb_PSEL) begin
            case (w_idx)
                GPIO_REG_LED:     apb_PRDATA[NUM_LEDS-1:0] = r_led_q;
                GPIO_REG_KEYS:    apb_PRDATA[NUM_KEYS-1:0] = w_stable;
                GPIO_REG_RISE_EN: apb_PRDATA[NUM_KEYS-1:0] = r_rise_en_q;
                GPIO_REG_FALL_EN: apb_PRDATA[NUM_KEYS-1:0] = r_fall_en_q;
                GPIO_REG_STATUS:  apb_PRDATA[NUM_KEYS-1:0] = r_status_q;
                default:          ;
            endcase
        end
    end

    assign leds = r_led_q ^ LED_INVERT;
    assign irq  = |r_status_q;

endmodule : gpio_irq_controller
`default_nettype wire

// File: tb/tb_gpio_irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_irq_controller
// Description : Directed self-checking bench for gpio_irq_controller
//               (LED_INVERT=3'b011, DEBOUNCE_CYCLES=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_irq_controller;

    localparam int NL = 3;
    localparam int NK = 2;

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic [NL-1:0] leds;
    logic [NK-1:0] keys    = '0;
    logic          irq;
    logic [4:0]    paddr   = '0;
    logic          psel    = 1'b0;
    logic          penable = 1'b0;
    logic          pready;
    logic          pwrite  = 1'b0;
    logic [31:0]   pwdata  = '0;
    logic [31:0]   prdata;

    int errors = 0;
    int checks = 0;

    gpio_irq_controller #(
        .NUM_LEDS        (NL),
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (16),
        .LED_INVERT      (3'b011),
        .KEY_INVERT      (2'b00)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .leds        (leds),
        .keys        (keys),
        .irq         (irq),
        .apb_PADDR   (paddr),
        .apb_PSEL    (psel),
        .apb_PENABLE (penable),
        .apb_PREADY  (pready),
        .apb_PWRITE  (pwrite),
        .apb_PWDATA  (pwdata),
        .apb_PRDATA  (prdata)
    );

    always #5 clk = ~clk;

    // Setup at one negedge, access at the next, commit on the following posedge
    task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        paddr = a; pwdata = d; psel = 1'b1; pwrite = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // Combinational read in the current low phase (call at a negedge)
    task automatic apb_read(input logic [4:0] a, output logic [31:0] d);
        paddr = a; psel = 1'b1; pwrite = 1'b0; penable = 1'b1;
        #1 d = prdata;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (leds !== 3'b011) begin errors++; $display("FAIL rst_leds: got %b exp %b", leds, 3'b011); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b exp 0", irq); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (pready !== 1'b1) begin errors++; $display("FAIL pready: got %b exp 1", pready); end
        for (int i = 0; i < 8; i++) begin
            apb_read(5'(i * 4), rd);
            checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_read_%0d: got %h exp 0", i, rd); end
        end
    endtask

    task automatic test_led();
        logic [31:0] rd;
        apb_write(5'h00, 32'hFFFF_FFF5);
        checks++; if (leds !== 3'b110) begin errors++; $display("FAIL led_pins: got %b exp %b", leds, 3'b110); end
        apb_read(5'h00, rd);
        checks++; if (rd !== 32'h5) begin errors++; $display("FAIL led_read: got %h exp %h", rd, 32'h5); end
    endtask

    task automatic test_debounce_rise();
        logic [31:0] rd;
        apb_write(5'h08, 32'h1);
        keys[0] = 1'b1;                  // during cycle t
        repeat (17) @(posedge clk);
        @(negedge clk);
        apb_read(5'h04, rd);
        checks++; if (rd !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL deb_early: keys=%h irq=%b exp keys=0 irq=0", rd, irq); end
        @(posedge clk);                  // posedge t+18
        @(negedge clk);
        apb_read(5'h04, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL deb_keys: got %h exp 1", rd); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL deb_irq: got %b exp 1", irq); end
        apb_write(5'h10, 32'h1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL deb_clr_irq: got %b exp 0", irq); end
    endtask

    task automatic test_glitch();
        logic [31:0] rd;
        apb_write(5'h08, 32'h3);
        keys[1] = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        keys[1] = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        apb_read(5'h04, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL glitch_keys: got %h exp 1", rd); end
        apb_read(5'h10, rd);
        checks++; if (rd !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL glitch_status: status=%h irq=%b exp 0/0", rd, irq); end
    endtask

    task automatic test_edge_select();
        logic [31:0] rd;
        apb_write(5'h0C, 32'h2);
        apb_write(5'h08, 32'h0);
        keys[1] = 1'b1;
        repeat (25) @(posedge clk);
        @(negedge clk);
        apb_read(5'h04, rd);
        checks++; if (rd !== 32'h3) begin errors++; $display("FAIL esel_keys: got %h exp 3", rd); end
        apb_read(5'h10, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL esel_press: got %h exp 0", rd); end
        keys[1] = 1'b0;
        repeat (25) @(posedge clk);
        @(negedge clk);
        apb_read(5'h10, rd);
        checks++; if (rd !== 32'h2 || irq !== 1'b1) begin errors++; $display("FAIL esel_release: status=%h irq=%b exp 2/1", rd, irq); end
        apb_write(5'h10, 32'h2);
        apb_read(5'h10, rd);
        checks++; if (rd !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL esel_w1c: status=%h irq=%b exp 0/0", rd, irq); end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] rd;
        apb_write(5'h08, 32'h1);
        apb_write(5'h0C, 32'h1);
        keys[0] = 1'b0;                  // enabled fall on key0
        repeat (25) @(posedge clk);
        @(negedge clk);
        apb_read(5'h10, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL coll_pre: got %h exp 1", rd); end
        keys[0] = 1'b1;                  // rise accepted at posedge t+18
        repeat (16) @(posedge clk);
        apb_write(5'h10, 32'h1);         // commits at posedge t+18
        apb_read(5'h10, rd);
        checks++; if (rd !== 32'h1 || irq !== 1'b1) begin errors++; $display("FAIL coll_set_wins: status=%h irq=%b exp 1/1", rd, irq); end
        apb_read(5'h04, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL coll_keys: got %h exp 1", rd); end
        apb_write(5'h10, 32'h1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL coll_clear: irq=%b exp 0", irq); end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd;
        apb_write(5'h14, 32'hFFFF_FFFF);
        apb_write(5'h04, 32'hFFFF_FFFF);
        apb_read(5'h00, rd);
        checks++; if (rd !== 32'h5 || leds !== 3'b110) begin errors++; $display("FAIL unm_led: reg=%h pins=%b exp 5/110", rd, leds); end
        apb_read(5'h08, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL unm_rise: got %h exp 1", rd); end
        apb_read(5'h0C, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL unm_fall: got %h exp 1", rd); end
        apb_read(5'h04, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL unm_keys: got %h exp 1", rd); end
        apb_read(5'h10, rd);
        checks++; if (rd !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL unm_status: status=%h irq=%b exp 0/0", rd, irq); end
        apb_read(5'h14, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unm_read14: got %h exp 0", rd); end
        apb_read(5'h18, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unm_read18: got %h exp 0", rd); end
    endtask

    task automatic test_reset_mid_count();
        logic [31:0] rd;
        keys[1] = 1'b1;                  // key0 still held high
        repeat (12) @(posedge clk);      // key1 counter reaches 10
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);       // last reset edge R
        @(negedge clk);
        reset = 1'b1;
        checks++; if (leds !== 3'b011 || irq !== 1'b0) begin errors++; $display("FAIL rmid_rst: leds=%b irq=%b exp 011/0", leds, irq); end
        apb_write(5'h08, 32'h3);         // commits at R+3
        repeat (14) @(posedge clk);      // through R+17
        @(negedge clk);
        apb_read(5'h04, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rmid_keys_early: got %h exp 0", rd); end
        apb_read(5'h10, rd);
        checks++; if (rd !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL rmid_status_early: status=%h irq=%b exp 0/0", rd, irq); end
        @(posedge clk);                  // R+18
        @(negedge clk);
        apb_read(5'h04, rd);
        checks++; if (rd !== 32'h3) begin errors++; $display("FAIL rmid_keys: got %h exp 3", rd); end
        apb_read(5'h10, rd);
        checks++; if (rd !== 32'h3 || irq !== 1'b1) begin errors++; $display("FAIL rmid_status: status=%h irq=%b exp 3/1", rd, irq); end
    endtask

    initial begin
        test_reset();
        test_led();
        test_debounce_rise();
        test_glitch();
        test_edge_select();
        test_w1c_collision();
        test_unmapped();
        test_reset_mid_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the sequence never completes
    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, exp sequence complete");
        $fatal(1, "timeout");
    end

endmodule : tb_gpio_irq_controller
`default_nettype wire
